alu_result_checker: RTL and testbench
=====================================

ALU_RESULT_CHECKER -- requirements
Module: alu_result_checker

Interface
REQ-001 Parameter: WIDTH, 8, operand/result width in bits.
REQ-002 Parameter: CNT_W, 8, width of all counters and the index register.
REQ-003 CLK  in  1  sole clock; all state updates on rising edge.
REQ-004 RESET  in  1  asynchronous, active-low; forces the reset state immediately while low.
REQ-005 START  in  1  begin or restart a checking session; single-cycle pulse.
REQ-006 STOP  in  1  end the session; single-cycle pulse.
REQ-007 VALID  in  1  DATA1/DATA2/SELECT/RESULT carry a sample this cycle.
REQ-008 SELECT  in  3  op: 000 FORWARD (DATA2), 001 ADD, 010 AND, 011 OR, 1xx illegal.
REQ-009 DATA1, DATA2  in  WIDTH  operands applied to the unit under test.
REQ-010 RESULT  in  WIDTH  result observed from the unit under test.
REQ-011 READY  out  1  checker accepts a sample this cycle.
REQ-012 BUSY  out  1  high in RUN and DRAIN.
REQ-013 DONE  out  1  high in DONE state.
REQ-014 ERR_PULSE  out  1  one-cycle pulse per mismatching sample.
REQ-015 ERR_STICKY  out  1  set on any mismatch; cleared only by reset or START.
REQ-016 ILLEGAL  out  1  sticky; set when an accepted sample has SELECT=1xx.
REQ-017 EXPECTED  out  WIDTH  registered expected value of the last accepted sample.
REQ-018 SAMPLE_CNT, ERR_CNT  out  CNT_W  accepted samples / mismatches in current session.
REQ-019 FIRST_ERR_IDX  out  CNT_W  SAMPLE_CNT value (0-based) of first mismatch; all-ones if none.

Function
REQ-020 FSM states IDLE, RUN, DRAIN, DONE; SHALL be one-hot or binary, not externally visible except via BUSY/DONE/READY.
REQ-021 IDLE->RUN on START; RUN->DRAIN on STOP; DRAIN->DONE after exactly one cycle; DONE->RUN on START; DONE holds otherwise.
REQ-022 START in RUN/DRAIN restarts: all counters, sticky flags, FIRST_ERR_IDX reinitialised, state RUN next cycle; pipeline sample in flight discarded.
REQ-023 START and STOP asserted together: START wins; STOP in IDLE or DONE ignored.
REQ-024 READY SHALL be combinationally 1 exactly in RUN; a sample is accepted when VALID and READY; VALID outside RUN ignored with no counter change.
REQ-025 STOP with VALID in the same RUN cycle: sample accepted, then DRAIN.
REQ-026 Stage 1 (accept edge): register RESULT, compute and register EXPECTED; SAMPLE_CNT increments on the same edge.
REQ-027 Stage 2 (next edge): compare; on mismatch ERR_PULSE high for that one cycle, ERR_CNT increments, ERR_STICKY set; FIRST_ERR_IDX captured only if still all-ones.
REQ-028 Latency: ERR_PULSE asserts one cycle after acceptance; back-to-back samples every cycle SHALL be supported.
REQ-029 DRAIN exists so the last sample's comparison completes before DONE; counters final when DONE rises.
REQ-030 ADD SHALL be modulo 2^WIDTH (carry discarded, two's-complement wrap); AND/OR bitwise; FORWARD = DATA2.
REQ-031 Illegal SELECT: EXPECTED = 0, sample counts as a mismatch, ILLEGAL set.
REQ-032 SAMPLE_CNT and ERR_CNT SHALL saturate at all-ones, never wrap.

Reset
REQ-033 While RESET low: state IDLE, READY/BUSY/DONE/ERR_PULSE/ERR_STICKY/ILLEGAL 0, EXPECTED 0, SAMPLE_CNT 0, ERR_CNT 0, FIRST_ERR_IDX all-ones.
REQ-034 Reset asserted mid-session SHALL abort it with no partial count update; after release, checker waits in IDLE for START.

Verification
REQ-035 START; OR samples (1,0,R=1),(0xD4,0x0A,R=0xDE),(15,11,R=15); STOP -> DONE, SAMPLE_CNT=3, ERR_CNT=0, FIRST_ERR_IDX=0xFF.
REQ-036 ADD (0x7F,0x01,R=0x80) then (0xFF,0x01,R=0x00) -> no error; then (3,4,R=8) -> ERR_PULSE one cycle after accept, ERR_CNT=1, FIRST_ERR_IDX=2.
REQ-037 SELECT=101 sample with R=0 -> ILLEGAL=1, ERR_CNT=1, EXPECTED=0.
REQ-038 300 back-to-back mismatching samples -> SAMPLE_CNT=ERR_CNT=255 (saturated); restart with START -> all counters 0, ERR_STICKY 0.
REQ-039 VALID in IDLE and DONE -> no counter change; STOP with VALID in same cycle -> sample counted, DONE two cycles later.
REQ-040 RESET pulled low asynchronously between edges in RUN -> outputs at reset values before next edge; START and STOP together in IDLE -> RUN.

Source files
------------

// File: rtl/alu_result_checker.sv
// rtl/alu_result_checker.sv - two-stage ALU result checker with session FSM and error bookkeeping
module alu_result_checker #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic             valid,
  input  logic [2:0]       select,
  input  logic [WIDTH-1:0] data1,
  input  logic [WIDTH-1:0] data2,
  input  logic [WIDTH-1:0] result,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic             err_pulse,
  output logic             err_sticky,
  output logic             illegal,
  output logic [WIDTH-1:0] expected,
  output logic [CNT_W-1:0] sample_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] first_err_idx
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONES = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   expected_q, expected_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               s1_valid_q, s1_valid_d;
  logic               s1_illegal_q, s1_illegal_d;
  logic [CNT_W-1:0]   s1_idx_q, s1_idx_d;
  logic               err_pulse_q, err_pulse_d;
  logic               err_sticky_q, err_sticky_d;
  logic               illegal_q, illegal_d;
  logic [CNT_W-1:0]   sample_cnt_q, sample_cnt_d;
  logic [CNT_W-1:0]   err_cnt_q, err_cnt_d;
  logic [CNT_W-1:0]   first_err_idx_q, first_err_idx_d;

  logic               accept;
  logic               mismatch;
  logic [WIDTH-1:0]   calc;

  always_comb begin
    calc = '0;
    case (select)
      3'b000:  calc = data2;
      3'b001:  calc = data1 + data2;
      3'b010:  calc = data1 & data2;
      3'b011:  calc = data1 | data2;
      default: calc = '0;
    endcase
  end

  // A start in the same cycle as a sample restarts the session and drops that sample.
  assign accept   = (state_q == S_RUN) && valid && !start;
  assign mismatch = s1_valid_q && (s1_illegal_q || (result_q != expected_q));

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_RUN;
      S_RUN:   if (start) state_d = S_RUN;
               else if (stop) state_d = S_DRAIN;
      S_DRAIN: state_d = start ? S_RUN : S_DONE;
      S_DONE:  if (start) state_d = S_RUN;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    expected_d      = expected_q;
    result_d        = result_q;
    s1_valid_d      = 1'b0;
    s1_illegal_d    = s1_illegal_q;
    s1_idx_d        = s1_idx_q;
    err_pulse_d     = 1'b0;
    err_sticky_d    = err_sticky_q;
    illegal_d       = illegal_q;
    sample_cnt_d    = sample_cnt_q;
    err_cnt_d       = err_cnt_q;
    first_err_idx_d = first_err_idx_q;

    if (start) begin
      err_sticky_d    = 1'b0;
      illegal_d       = 1'b0;
      sample_cnt_d    = '0;
      err_cnt_d       = '0;
      first_err_idx_d = CNT_ONES;
    end else begin
      if (accept) begin
        result_d     = result;
        expected_d   = calc;
        s1_valid_d   = 1'b1;
        s1_illegal_d = select[2];
        s1_idx_d     = sample_cnt_q;
        if (select[2]) illegal_d = 1'b1;
        if (sample_cnt_q != CNT_ONES) sample_cnt_d = sample_cnt_q + CNT_ONE;
      end
      if (mismatch) begin
        err_pulse_d  = 1'b1;
        err_sticky_d = 1'b1;
        if (err_cnt_q != CNT_ONES) err_cnt_d = err_cnt_q + CNT_ONE;
        if (first_err_idx_q == CNT_ONES) first_err_idx_d = s1_idx_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= S_IDLE;
      expected_q      <= '0;
      result_q        <= '0;
      s1_valid_q      <= 1'b0;
      s1_illegal_q    <= 1'b0;
      s1_idx_q        <= '0;
      err_pulse_q     <= 1'b0;
      err_sticky_q    <= 1'b0;
      illegal_q       <= 1'b0;
      sample_cnt_q    <= '0;
      err_cnt_q       <= '0;
      first_err_idx_q <= CNT_ONES;
    end else begin
      state_q         <= state_d;
      expected_q      <= expected_d;
      result_q        <= result_d;
      s1_valid_q      <= s1_valid_d;
      s1_illegal_q    <= s1_illegal_d;
      s1_idx_q        <= s1_idx_d;
      err_pulse_q     <= err_pulse_d;
      err_sticky_q    <= err_sticky_d;
      illegal_q       <= illegal_d;
      sample_cnt_q    <= sample_cnt_d;
      err_cnt_q       <= err_cnt_d;
      first_err_idx_q <= first_err_idx_d;
    end
  end

  assign ready         = (state_q == S_RUN);
  assign busy          = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign done          = (state_q == S_DONE);
  assign err_pulse     = err_pulse_q;
  assign err_sticky    = err_sticky_q;
  assign illegal       = illegal_q;
  assign expected      = expected_q;
  assign sample_cnt    = sample_cnt_q;
  assign err_cnt       = err_cnt_q;
  assign first_err_idx = first_err_idx_q;

endmodule

// File: tb/tb_alu_result_checker.sv
// tb/tb_alu_result_checker.sv - scoreboard bench for alu_result_checker
module tb_alu_result_checker;
  localparam int W = 8;
  localparam int C = 8;

  logic         clk = 1'b0;
  logic         rst_n, start, stop, valid;
  logic [2:0]   select;
  logic [W-1:0] data1, data2, result;
  logic         ready, busy, done, err_pulse, err_sticky, illegal;
  logic [W-1:0] expected;
  logic [C-1:0] sample_cnt, err_cnt, first_err_idx;

  always #5 clk = ~clk;

  alu_result_checker #(.WIDTH(W), .CNT_W(C)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .valid(valid),
    .select(select), .data1(data1), .data2(data2), .result(result),
    .ready(ready), .busy(busy), .done(done), .err_pulse(err_pulse),
    .err_sticky(err_sticky), .illegal(illegal), .expected(expected),
    .sample_cnt(sample_cnt), .err_cnt(err_cnt), .first_err_idx(first_err_idx)
  );

  typedef struct {
    logic [W-1:0] exp;
    logic         mis;
  } item_t;

  item_t q[$];
  item_t s1, s2;
  bit    s1_v = 0, s2_v = 0;
  int    checks = 0, errors = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, got, want, $time);
    end
  endtask

  // Monitor: an acceptance seen before an edge yields EXPECTED after it and ERR_PULSE one edge later.
  always @(negedge clk) begin
    if (s2_v) check("err_pulse", {31'b0, err_pulse}, {31'b0, s2.mis});
    else      check("no_err_pulse", {31'b0, err_pulse}, 32'd0);
    if (s1_v) check("expected", {24'b0, expected}, {24'b0, s1.exp});
    s2_v = s1_v;
    s2   = s1;
    s1_v = rst_n && ready && valid && !start;
    if (s1_v) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL scoreboard_underflow: got accept, want none (t=%0t)", $time);
        s1_v = 0;
      end else begin
        s1 = q.pop_front();
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [2:0] sel, input logic [W-1:0] d1, input logic [W-1:0] d2,
                      input logic [W-1:0] r, input logic [W-1:0] e, input logic m, input logic stp);
    item_t it;
    valid = 1'b1; select = sel; data1 = d1; data2 = d2; result = r; stop = stp;
    it.exp = e; it.mis = m;
    q.push_back(it);
    tick(1);
    valid = 1'b0; stop = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(1); start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1; tick(1); stop = 1'b0;
  endtask

  task automatic check_counts(input string tag, input int sc, input int ec, input int fi);
    check({tag, "_sample_cnt"}, {24'b0, sample_cnt}, sc);
    check({tag, "_err_cnt"}, {24'b0, err_cnt}, ec);
    check({tag, "_first_err_idx"}, {24'b0, first_err_idx}, fi);
  endtask

  initial begin
    logic [W-1:0] v;
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; valid = 1'b0;
    select = '0; data1 = '0; data2 = '0; result = '0;
    tick(2);
    check("rst_ready", {31'b0, ready}, 0);
    check("rst_busy", {31'b0, busy}, 0);
    check("rst_done", {31'b0, done}, 0);
    check("rst_sticky", {31'b0, err_sticky}, 0);
    check("rst_illegal", {31'b0, illegal}, 0);
    check("rst_expected", {24'b0, expected}, 0);
    check_counts("rst", 0, 0, 8'hFF);
    rst_n = 1'b1;
    tick(1);

    // OR session, all matching
    pulse_start();
    check("run_ready", {31'b0, ready}, 1);
    check("run_busy", {31'b0, busy}, 1);
    send(3'b011, 8'h01, 8'h00, 8'h01, 8'h01, 1'b0, 1'b0);
    send(3'b011, 8'hD4, 8'h0A, 8'hDE, 8'hDE, 1'b0, 1'b0);
    send(3'b011, 8'h0F, 8'h0B, 8'h0F, 8'h0F, 1'b0, 1'b0);
    pulse_stop();
    check("drain_busy", {31'b0, busy}, 1);
    check("drain_done", {31'b0, done}, 0);
    tick(1);
    check("or_done", {31'b0, done}, 1);
    check("or_ready", {31'b0, ready}, 0);
    check("or_sticky", {31'b0, err_sticky}, 0);
    check_counts("or", 3, 0, 8'hFF);

    // ADD wrap, then a mismatch at index 2
    pulse_start();
    send(3'b001, 8'h7F, 8'h01, 8'h80, 8'h80, 1'b0, 1'b0);
    send(3'b001, 8'hFF, 8'h01, 8'h00, 8'h00, 1'b0, 1'b0);
    send(3'b001, 8'h03, 8'h04, 8'h08, 8'h07, 1'b1, 1'b0);
    pulse_stop();
    tick(1);
    check("add_done", {31'b0, done}, 1);
    check("add_sticky", {31'b0, err_sticky}, 1);
    check("add_illegal", {31'b0, illegal}, 0);
    check_counts("add", 3, 1, 2);

    // AND, FORWARD, then illegal select
    pulse_start();
    send(3'b010, 8'hF0, 8'h3C, 8'h30, 8'h30, 1'b0, 1'b0);
    send(3'b000, 8'hAA, 8'h55, 8'h55, 8'h55, 1'b0, 1'b0);
    send(3'b101, 8'h05, 8'h06, 8'h00, 8'h00, 1'b1, 1'b0);
    pulse_stop();
    tick(1);
    check("ill_illegal", {31'b0, illegal}, 1);
    check("ill_expected", {24'b0, expected}, 0);
    check_counts("ill", 3, 1, 2);

    // Saturation with 300 back-to-back mismatches
    pulse_start();
    check("restart_illegal", {31'b0, illegal}, 0);
    for (int i = 0; i < 300; i++) begin
      v = W'(i);
      send(3'b000, 8'h11, v, ~v, v, 1'b1, 1'b0);
    end
    pulse_stop();
    tick(1);
    check("sat_sticky", {31'b0, err_sticky}, 1);
    check_counts("sat", 255, 255, 0);
    pulse_start();
    check("rs_busy", {31'b0, busy}, 1);
    check("rs_sticky", {31'b0, err_sticky}, 0);
    check_counts("rs", 0, 0, 8'hFF);

    // VALID in DONE ignored; STOP together with VALID
    pulse_stop();
    tick(1);
    check("d_done", {31'b0, done}, 1);
    valid = 1'b1; select = 3'b001; data1 = 8'h01; data2 = 8'h01; result = 8'h07;
    tick(3);
    valid = 1'b0;
    check("d_ready", {31'b0, ready}, 0);
    check_counts("dvalid", 0, 0, 8'hFF);
    pulse_start();
    send(3'b010, 8'hF0, 8'h0F, 8'h00, 8'h00, 1'b0, 1'b1);
    check("sv_busy", {31'b0, busy}, 1);
    check("sv_done", {31'b0, done}, 0);
    tick(1);
    check("sv_done2", {31'b0, done}, 1);
    check_counts("sv", 1, 0, 8'hFF);

    // Asynchronous reset in RUN
    pulse_start();
    send(3'b001, 8'h02, 8'h02, 8'h05, 8'h04, 1'b1, 1'b0);
    tick(3);
    check("pre_rst_sticky", {31'b0, err_sticky}, 1);
    check_counts("pre_rst", 1, 1, 0);
    #2 rst_n = 1'b0;
    #1;
    check("arst_ready", {31'b0, ready}, 0);
    check("arst_busy", {31'b0, busy}, 0);
    check("arst_sticky", {31'b0, err_sticky}, 0);
    check("arst_expected", {24'b0, expected}, 0);
    check_counts("arst", 0, 0, 8'hFF);
    tick(1);
    rst_n = 1'b1;
    valid = 1'b1; select = 3'b000; data2 = 8'h33; result = 8'h00;
    tick(2);
    valid = 1'b0;
    check("idle_busy", {31'b0, busy}, 0);
    check_counts("idle", 0, 0, 8'hFF);
    start = 1'b1; stop = 1'b1;
    tick(1);
    start = 1'b0; stop = 1'b0;
    check("ss_ready", {31'b0, ready}, 1);
    check("ss_done", {31'b0, done}, 0);
    tick(1);
    check("ss_busy", {31'b0, busy}, 1);

    tick(3);
    check("scoreboard_empty", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
